toggle_phase_accumulator: RTL and testbench

- Sits directly downstream of the 8-bit one-hot ring counter in the power estimation datapath.
- Uses the counter's one-hot phase to bin switching activity of a monitored bus into 8 time-slot accumulators over a window of ring rotations.
- At window end, drains the 8 slot totals in slot order over a valid/ready interface to the power model stage.
- Each accumulation cycle adds the Hamming distance between the current and previous bus samples to the slot selected by the phase.

---
 rtl/toggle_phase_accumulator.sv | 131 +++++++++++++
 tb/tb_toggle_phase_accumulator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_phase_accumulator.sv
// Bins bus toggle counts (Hamming distance per cycle) into 8 phase slots over WIN ring
// rotations, then drains the slot totals in order. Optional macro: PHASE_ONEHOT_CHECK_EN.
module toggle_phase_accumulator #(
    parameter int DW    = 16,
    parameter int ACC_W = 24,
    parameter int WIN   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       phase,
    input  logic [DW-1:0]    sig_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_slot,
    output logic [ACC_W-1:0] out_count,
    output logic             phase_err
);

    localparam int HD_W = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc [8];
    logic [DW-1:0]    prev;
    logic [7:0]       rot_cnt;
    logic [2:0]       drain_idx;

    logic [HD_W-1:0]  hd;
    logic [2:0]       slot;
    logic             phase_ok;
    logic             acc_en;
    logic             rot_done;
    logic             last_rot;
    logic             handshake;
    logic             last_out;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sat_sum;

    assign hd = HD_W'($countones(sig_in ^ prev));

    // Lowest set bit wins, so iterate from the top down; all-zero phase falls back to slot 0.
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        slot = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (phase[k]) slot = 3'(k);
        end
    end

`ifdef PHASE_ONEHOT_CHECK_EN
    assign phase_ok = $onehot(phase);
`else
    assign phase_ok = 1'b1;
`endif

    assign acc_en    = (state == ACCUM) && phase_ok;
    assign rot_done  = acc_en && phase[7];
    assign last_rot  = rot_done && (rot_cnt == 8'(WIN - 1));
    assign handshake = (state == DRAIN) && out_ready;
    assign last_out  = handshake && (drain_idx == 3'd7);

    // One extra bit catches the carry so the total clamps at all-ones instead of wrapping.
    assign sum     = {1'b0, acc[slot]} + (ACC_W + 1)'(hd);
    assign sat_sum = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = ACCUM;
            ACCUM:   if (last_rot) state_next = DRAIN;
            DRAIN:   if (last_out) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: the slot array is only 8 words of flops, so it is reset directly; an abort must leave no stale totals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= '0;
            rot_cnt   <= '0;
            drain_idx <= '0;
            for (int k = 0; k < 8; k++) acc[k] <= '0;
        end else begin
            prev <= sig_in;
            if (acc_en)   acc[slot] <= sat_sum;
            if (rot_done) rot_cnt   <= rot_cnt + 8'd1;
            if (handshake) begin
                drain_idx <= drain_idx + 3'd1;
                if (last_out) begin
                    rot_cnt <= '0;
                    for (int k = 0; k < 8; k++) acc[k] <= '0;
                end
            end
        end
    end

`ifdef PHASE_ONEHOT_CHECK_EN
    logic phase_err_q;

    // Sticky until the next accepted start so the consumer can qualify the whole window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          phase_err_q <= 1'b0;
        else if (state == IDLE && start)     phase_err_q <= 1'b0;
        else if (state == ACCUM && !phase_ok) phase_err_q <= 1'b1;
    end

    assign phase_err = phase_err_q;
`else
    assign phase_err = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign out_valid = (state == DRAIN);
    assign out_slot  = drain_idx;
    assign out_count = acc[drain_idx];

endmodule

// File: tb/tb_toggle_phase_accumulator.sv
// Scoreboard bench for toggle_phase_accumulator: one instance with WIN=1, ACC_W=24 and one
// saturating instance with WIN=4, ACC_W=5, sharing the phase and bus stimulus.
module tb_toggle_phase_accumulator;

    typedef struct {
        logic [2:0]  slot;
        logic [23:0] count;
    } exp_t;

`ifdef PHASE_ONEHOT_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  phase = '0;
    logic [15:0] sig_in = '0;

    logic        start_a = 1'b0, rdy_a = 1'b1;
    logic        busy_a, valid_a, err_a;
    logic [2:0]  slot_a;
    logic [23:0] count_a;

    logic        start_s = 1'b0, rdy_s = 1'b1;
    logic        busy_s, valid_s, err_s;
    logic [2:0]  slot_s;
    logic [4:0]  count_s;

    exp_t q_a[$];
    exp_t q_s[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    toggle_phase_accumulator #(.DW(16), .ACC_W(24), .WIN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .phase(phase), .sig_in(sig_in),
        .busy(busy_a), .out_valid(valid_a), .out_ready(rdy_a), .out_slot(slot_a),
        .out_count(count_a), .phase_err(err_a)
    );

    toggle_phase_accumulator #(.DW(16), .ACC_W(5), .WIN(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .phase(phase), .sig_in(sig_in),
        .busy(busy_s), .out_valid(valid_s), .out_ready(rdy_s), .out_slot(slot_s),
        .out_count(count_s), .phase_err(err_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitors: every accepted result is compared against the head of its queue.
    always @(negedge clk) begin
        if (valid_a && rdy_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_result slot=%0d count=%0d", slot_a, count_a);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_slot", 32'(slot_a), 32'(e.slot));
                check("a_count", 32'(count_a), 32'(e.count));
            end
        end
    end

    always @(negedge clk) begin
        if (valid_s && rdy_s) begin
            if (q_s.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL s_unexpected_result slot=%0d count=%0d", slot_s, count_s);
            end else begin
                exp_t e;
                e = q_s.pop_front();
                check("s_slot", 32'(slot_s), 32'(e.slot));
                check("s_count", 32'(count_s), 32'(e.count));
            end
        end
    end

    task automatic push_a(input logic [2:0] s, input logic [23:0] c);
        exp_t e;
        e.slot = s;
        e.count = c;
        q_a.push_back(e);
    endtask

    task automatic push_s(input logic [2:0] s, input logic [23:0] c);
        exp_t e;
        e.slot = s;
        e.count = c;
        q_s.push_back(e);
    endtask

    task automatic step(input logic [7:0] p, input logic [15:0] s);
        phase = p;
        sig_in = s;
        @(posedge clk);
        #1;
    endtask

    // ramp=0: every cycle toggles all 16 bits. ramp=1: the slot-k cycle toggles k+1 bits.
    // illegal_at >= 0 inserts one phase=0x18 cycle toggling all 16 bits before that slot.
    task automatic run_window(input bit use_s, input int rots, input bit ramp, input int illegal_at);
        logic [15:0] s;
        s = '0;
        phase = '0;
        sig_in = s;
        if (use_s) start_s = 1'b1;
        else       start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_s = 1'b0;
        check("busy_after_start", use_s ? busy_s : busy_a, 1);
        for (int r = 0; r < rots; r++) begin
            for (int k = 0; k < 8; k++) begin
                if (r == 0 && k == illegal_at) begin
                    s = ~s;
                    step(8'h18, s);
                    check("phase_err_after_illegal", err_a, 32'(CHK_EN));
                end
                s = s ^ (ramp ? 16'((17'd1 << (k + 1)) - 17'd1) : 16'hFFFF);
                step(8'(1 << k), s);
            end
        end
        phase = '0;
        check("valid_after_window", use_s ? valid_s : valid_a, 1);
    endtask

    task automatic wait_done(input bit use_s);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!(use_s ? busy_s : busy_a)) break;
        end
        check("drain_complete", use_s ? busy_s : busy_a, 0);
        check("queue_empty", use_s ? q_s.size() : q_a.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_busy", busy_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_slot", slot_a, 0);
        check("rst_count", count_a, 0);
        check("rst_phase_err", err_a, 0);
        check("rst_s_valid", valid_s, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic window: 16 toggles per slot.
        for (int k = 0; k < 8; k++) push_a(3'(k), 24'd16);
        run_window(1'b0, 1, 1'b0, -1);
        wait_done(1'b0);

        // Saturation: 4 rotations x 16 = 64 clamps to 31 on a 5-bit accumulator.
        for (int k = 0; k < 8; k++) push_s(3'(k), 24'd31);
        run_window(1'b1, 4, 1'b0, -1);
        wait_done(1'b1);

        // Backpressure: slot k holds k+1 toggles; stall 5 cycles on slot 3.
        for (int k = 0; k < 8; k++) push_a(3'(k), 24'(k + 1));
        run_window(1'b0, 1, 1'b1, -1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (slot_a == 3'd2) break;
        end
        check("reached_slot2", slot_a, 2);
        @(posedge clk);
        #1;
        rdy_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", valid_a, 1);
            check("bp_slot", slot_a, 3);
            check("bp_count", count_a, 4);
        end
        @(posedge clk);
        #1;
        rdy_a = 1'b1;
        wait_done(1'b0);

        // Reset mid-drain, then a fresh window must show only new totals.
        for (int k = 0; k < 8; k++) push_a(3'(k), 24'(k + 1));
        run_window(1'b0, 1, 1'b1, -1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (slot_a == 3'd2) break;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", valid_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_slot", slot_a, 0);
        check("mid_rst_count", count_a, 0);
        q_a.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) push_a(3'(k), 24'd16);
        run_window(1'b0, 1, 1'b0, -1);
        wait_done(1'b0);

        // Illegal phase 0x18 before slot 3: dropped when checked, lands in slot 3 otherwise.
        for (int k = 0; k < 8; k++) push_a(3'(k), (k == 3 && !CHK_EN) ? 24'd32 : 24'd16);
        run_window(1'b0, 1, 1'b0, 3);
        wait_done(1'b0);
        check("phase_err_sticky", err_a, 32'(CHK_EN));

        // Next accepted start clears the sticky flag.
        for (int k = 0; k < 8; k++) push_a(3'(k), 24'd16);
        run_window(1'b0, 1, 1'b0, -1);
        check("phase_err_cleared", err_a, 0);
        wait_done(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
